multiplicador_secuencial: RTL and testbench
===========================================

MULTIPLICADOR_SECUENCIAL -- requirements
Module: multiplicador_secuencial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits.
REQ-002 The block SHALL have input clk, 1 bit: single 100 MHz system clock; all state updates on posedge clk.
REQ-003 The block SHALL have input reset, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have input multiplicador, WIDTH bits: debounced multiplier operand.
REQ-005 The block SHALL have input multiplicando, WIDTH bits: debounced multiplicand operand.
REQ-006 The block SHALL have input pushbutton_salida, 1 bit: debounced, 500 ms-qualified start level.
REQ-007 The block SHALL have output producto, 2*WIDTH bits: last completed product, held between operations.
REQ-008 The block SHALL have output valido, 1 bit: one-cycle pulse when producto updates.
REQ-009 The block SHALL have output ocupado, 1 bit: high while an operation is in progress.

Function
REQ-010 The block SHALL detect a start as a 0->1 transition of pushbutton_salida registered on clk; a held-high level SHALL NOT retrigger.
REQ-011 The block SHALL implement FSM states IDLE, LOAD, CALC and DONE.
REQ-012 The FSM SHALL go IDLE->LOAD on a start edge; LOAD->CALC after one cycle; CALC->DONE after exactly WIDTH CALC cycles; DONE->IDLE after one cycle.
REQ-013 In LOAD the block SHALL capture both operands into internal registers, clear a 2*WIDTH accumulator, and clear the iteration counter; operand changes after LOAD SHALL NOT affect the result.
REQ-014 Each CALC cycle SHALL add the shifted multiplicand to the accumulator if the multiplier LSB is 1, then shift the multiplicand left by 1 and the multiplier right by 1, and increment the counter.
REQ-015 The accumulator SHALL be 2*WIDTH bits, and no carry SHALL be lost for all operand values (255*255=65025 representable for WIDTH=8).
REQ-016 In DONE the block SHALL load producto from the accumulator and assert valido for exactly that cycle.
REQ-017 The latency from the first cycle of the registered start edge to the valido pulse SHALL be WIDTH+2 cycles (10 for WIDTH=8).
REQ-018 ocupado SHALL be 1 in LOAD and CALC, and 0 in IDLE and DONE.
REQ-019 Start edges arriving in LOAD, CALC or DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 A zero operand SHALL still take the full WIDTH CALC cycles and SHALL give producto=0.

Reset
REQ-021 On reset=0, at any time including mid-CALC, the block SHALL immediately set the state to IDLE and clear producto, valido, ocupado, the accumulator, the counter, operand registers and the edge-detect register.
REQ-022 After reset deasserts, a pushbutton_salida already high SHALL NOT start an operation; a fresh 0->1 edge SHALL be required.

Configuration
REQ-023 When MULT_SIGNED_EN is defined, the block SHALL treat operands as two's complement: LOAD stores magnitudes and the sign XOR, and DONE negates the accumulator when the XOR is 1.
REQ-024 With MULT_SIGNED_EN defined, latency SHALL be unchanged, and -128*-128 SHALL give +16384.
REQ-025 When MULT_SIGNED_EN is undefined, the block SHALL perform an unsigned multiply only, and no sign logic SHALL be synthesized.

Structure
REQ-026 Package mult_pkg SHALL hold the FSM state enum typedef, the default WIDTH constant, and the counter-width function (clog2 of WIDTH+1).
REQ-027 The block SHALL contain one sub-module, detector_flanco, a registered rising-edge detector with async active-low reset, used for start.

Verification
REQ-028 The bench SHALL check: multiplicador=13, multiplicando=11, start edge -> valido after 10 cycles, producto=143, ocupado high for 9 cycles.
REQ-029 The bench SHALL check: 255*255 -> producto=65025 (0xFE01); 0*200 -> producto=0, with the same 10-cycle latency.
REQ-030 The bench SHALL check: pushbutton_salida held high for 50 cycles -> exactly one valido pulse.
REQ-031 The bench SHALL check: operands changed during CALC (13*11 -> 2*2) -> producto=143.
REQ-032 The bench SHALL check: reset=0 at CALC cycle 4 -> outputs zero at once, state IDLE; after release, button still high -> no operation.
REQ-033 The bench SHALL check, with MULT_SIGNED_EN defined: 0xFD*0x05 (-3*5) -> producto=0xFFF1; 0x80*0x80 -> 0x4000.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bits needed to count 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector for a synchronous, debounced level. Only arms after the
// input has been seen low, so a level already high at reset release never fires.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic senal,
  output logic flanco
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;

  // NOTE: every signal driven in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    prev_d  = senal;
    armed_d = armed_q | ~senal;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign flanco = senal & ~prev_q & armed_q;

endmodule

// File: rtl/multiplicador_secuencial.sv
// Sequential shift-and-add multiplier: IDLE -> LOAD -> CALC (WIDTH cycles) -> DONE.
// Define MULT_SIGNED_EN for two's-complement operands (magnitude multiply plus sign fix-up).
module multiplicador_secuencial
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     multiplicador,
  input  logic [WIDTH-1:0]     multiplicando,
  input  logic                 pushbutton_salida,
  output logic [2*WIDTH-1:0]   producto,
  output logic                 valido,
  output logic                 ocupado
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic start;

  detector_flanco u_detector_flanco (
    .clk    (clk),
    .reset  (reset),
    .senal  (pushbutton_salida),
    .flanco (start)
  );

  state_e               state_q,    state_d;
  logic [CW-1:0]        cnt_q,      cnt_d;
  logic [2*WIDTH-1:0]   acc_q,      acc_d;
  logic [2*WIDTH-1:0]   mcand_q,    mcand_d;
  logic [WIDTH-1:0]     mplier_q,   mplier_d;
  logic [2*WIDTH-1:0]   producto_q, producto_d;
  logic                 valido_q,   valido_d;
  logic                 ocupado_q,  ocupado_d;
`ifdef MULT_SIGNED_EN
  logic                 neg_q,      neg_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    producto_d = producto_q;
    valido_d   = 1'b0;
    ocupado_d  = ocupado_q;
`ifdef MULT_SIGNED_EN
    neg_d      = neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          ocupado_d = 1'b1;
        end
      end

      LOAD: begin
`ifdef MULT_SIGNED_EN
        // Unary minus of the most negative value wraps to itself, which is its magnitude unsigned.
        mcand_d  = {{WIDTH{1'b0}}, multiplicando[WIDTH-1] ? -multiplicando : multiplicando};
        mplier_d = multiplicador[WIDTH-1] ? -multiplicador : multiplicador;
        neg_d    = multiplicando[WIDTH-1] ^ multiplicador[WIDTH-1];
`else
        mcand_d  = {{WIDTH{1'b0}}, multiplicando};
        mplier_d = multiplicador;
`endif
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = CALC;
      end

      CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        // Product lands on the same edge that enters DONE so valido and producto align.
        if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          ocupado_d = 1'b0;
          valido_d  = 1'b1;
`ifdef MULT_SIGNED_EN
          producto_d = neg_q ? -acc_d : acc_d;
`else
          producto_d = acc_d;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      producto_q <= '0;
      valido_q   <= 1'b0;
      ocupado_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      producto_q <= producto_d;
      valido_q   <= valido_d;
      ocupado_q  <= ocupado_d;
`ifdef MULT_SIGNED_EN
      neg_q      <= neg_d;
`endif
    end
  end

  assign producto = producto_q;
  assign valido   = valido_q;
  assign ocupado  = ocupado_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Self-checking bench for multiplicador_secuencial: vector table, corner sequences, random operands.
module tb_multiplicador_secuencial;
  import mult_pkg::*;

  localparam int W       = 8;
  localparam int LATENCY = W + 2;
  localparam int BUSY    = W + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   multiplicador;
  logic [W-1:0]   multiplicando;
  logic           pushbutton_salida;
  logic [2*W-1:0] producto;
  logic           valido;
  logic           ocupado;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiplicador_secuencial #(.WIDTH(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .multiplicador     (multiplicador),
    .multiplicando     (multiplicando),
    .pushbutton_salida (pushbutton_salida),
    .producto          (producto),
    .valido            (valido),
    .ocupado           (ocupado)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_u;
    logic [2*W-1:0] exp_s;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product: widen both operands (sign- or zero-extended) and keep the low 2W bits.
  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
`ifdef MULT_SIGNED_EN
    ea = {{W{a[W-1]}}, a};
    eb = {{W{b[W-1]}}, b};
`else
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
`endif
    return ea * eb;
  endfunction

  // One operation: raise the button, watch a fixed window of cycles sampled on negedge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int window,
                        input int chg_at, input logic [W-1:0] ca, input logic [W-1:0] cb,
                        input int retrig_at,
                        output int lat, output int pulses, output int busy,
                        output logic [2*W-1:0] prod);
    lat = -1; pulses = 0; busy = 0; prod = '0;
    @(negedge clk);
    multiplicador = a;
    multiplicando = b;
    pushbutton_salida = 1'b1;
    for (int i = 1; i <= window; i++) begin
      @(negedge clk);
      if (i == chg_at) begin
        multiplicador = ca;
        multiplicando = cb;
      end
      if (i == retrig_at) pushbutton_salida = 1'b0;
      if (i == retrig_at + 1) pushbutton_salida = 1'b1;
      if (ocupado) busy++;
      if (valido) begin
        pulses++;
        if (lat < 0) begin
          lat  = i;
          prod = producto;
        end
      end
    end
    pushbutton_salida = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  vec_t           vecs [8];
  int             lat, pulses, busy;
  logic [2*W-1:0] prod, exp;
  logic [W-1:0]   ra, rb;

  initial begin
    vecs[0] = '{a: 8'd13,  b: 8'd11,  exp_u: 16'd143,   exp_s: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, exp_u: 16'hFE01,  exp_s: 16'h0001};
    vecs[2] = '{a: 8'd0,   b: 8'd200, exp_u: 16'd0,     exp_s: 16'd0};
    vecs[3] = '{a: 8'd200, b: 8'd0,   exp_u: 16'd0,     exp_s: 16'd0};
    vecs[4] = '{a: 8'hFD,  b: 8'h05,  exp_u: 16'h04F1,  exp_s: 16'hFFF1};
    vecs[5] = '{a: 8'h80,  b: 8'h80,  exp_u: 16'h4000,  exp_s: 16'h4000};
    vecs[6] = '{a: 8'd255, b: 8'd1,   exp_u: 16'h00FF,  exp_s: 16'hFFFF};
    vecs[7] = '{a: 8'd127, b: 8'd127, exp_u: 16'h3F01,  exp_s: 16'h3F01};

    reset = 1'b0;
    multiplicador = '0;
    multiplicando = '0;
    pushbutton_salida = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_producto", 32'(producto), 32'h0);
    check("reset_valido", 32'(valido), 32'h0);
    check("reset_ocupado", 32'(ocupado), 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
`ifdef MULT_SIGNED_EN
      exp = vecs[v].exp_s;
`else
      exp = vecs[v].exp_u;
`endif
      run_op(vecs[v].a, vecs[v].b, 14, 0, '0, '0, 0, lat, pulses, busy, prod);
      check($sformatf("vec%0d_producto", v), 32'(prod), 32'(exp));
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(LATENCY));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(BUSY));
      check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'd1);
      check($sformatf("vec%0d_held", v), 32'(producto), 32'(exp));
    end

    // Button held high for 50 cycles gives exactly one operation.
    run_op(8'd5, 8'd6, 50, 0, '0, '0, 0, lat, pulses, busy, prod);
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_producto", 32'(prod), 32'd30);

    // Operands changed mid-CALC must not alter the result.
    run_op(8'd13, 8'd11, 14, 4, 8'd2, 8'd2, 0, lat, pulses, busy, prod);
    check("opchg_producto", 32'(prod), 32'd143);
    check("opchg_latency", 32'(lat), 32'(LATENCY));

    // A fresh edge during CALC is dropped, not queued.
    run_op(8'd7, 8'd9, 30, 0, '0, '0, 4, lat, pulses, busy, prod);
    check("retrig_pulses", 32'(pulses), 32'd1);
    check("retrig_producto", 32'(prod), 32'(model_mul(8'd7, 8'd9)));

    // Reset in CALC cycle 4 with the button left high.
    @(negedge clk);
    multiplicador = 8'd13;
    multiplicando = 8'd11;
    pushbutton_salida = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_busy_before", 32'(ocupado), 32'd1);
    check("midrst_state_before", 32'(dut.state_q), 32'(CALC));
    reset = 1'b0;
    #1;
    check("midrst_producto", 32'(producto), 32'h0);
    check("midrst_valido", 32'(valido), 32'h0);
    check("midrst_ocupado", 32'(ocupado), 32'h0);
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    busy = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ocupado) busy++;
      if (valido) pulses++;
    end
    check("postrst_no_start_busy", 32'(busy), 32'd0);
    check("postrst_no_start_valido", 32'(pulses), 32'd0);
    check("postrst_producto", 32'(producto), 32'h0);
    pushbutton_salida = 1'b0;
    repeat (2) @(negedge clk);
    run_op(8'd9, 8'd9, 14, 0, '0, '0, 0, lat, pulses, busy, prod);
    check("recover_producto", 32'(prod), 32'd81);
    check("recover_latency", 32'(lat), 32'(LATENCY));

    // Random operands against the arithmetic model.
    for (int r = 0; r < 16; r++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      run_op(ra, rb, 14, 0, '0, '0, 0, lat, pulses, busy, prod);
      check($sformatf("rand%0d_%0d_x_%0d", r, ra, rb), 32'(prod), 32'(model_mul(ra, rb)));
      check($sformatf("rand%0d_latency", r), 32'(lat), 32'(LATENCY));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
